// File: rtl/noc_pkt_pkg.sv
// Shared NoC packet definitions: AXI-Stream channel types, routing header field
// offsets (reused by the router arbiter), packetizer FSM states and header packing.
package noc_pkt_pkg;

  localparam int AXIS_TDATA_W = 32;
  localparam int NOC_X_W      = 2;
  localparam int NOC_Y_W      = 2;

  localparam int HDR_DX_LSB = 0;
  localparam int HDR_DY_LSB = HDR_DX_LSB + NOC_X_W;
  localparam int HDR_SX_LSB = HDR_DY_LSB + NOC_Y_W;
  localparam int HDR_SY_LSB = HDR_SX_LSB + NOC_X_W;

  typedef struct packed {
    logic [AXIS_TDATA_W-1:0] tdata;
    logic                    tvalid;
    logic                    tlast;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;

  typedef enum logic [1:0] {IDLE, BODY, CONT} packetizer_state_t;

  function automatic logic [AXIS_TDATA_W-1:0] pack_header(
    input logic [NOC_X_W-1:0] dx,
    input logic [NOC_Y_W-1:0] dy,
    input logic [NOC_X_W-1:0] sx,
    input logic [NOC_Y_W-1:0] sy
  );
    logic [AXIS_TDATA_W-1:0] hdr;
    hdr = '0;
    hdr[HDR_DX_LSB +: NOC_X_W] = dx;
    hdr[HDR_DY_LSB +: NOC_Y_W] = dy;
    hdr[HDR_SX_LSB +: NOC_X_W] = sx;
    hdr[HDR_SY_LSB +: NOC_Y_W] = sy;
    return hdr;
  endfunction

endpackage

// File: rtl/axis_packetizer.sv
// Prepends a routing header to node payload bursts and splits them into packets of
// at most MAX_PACKAGES body flits. Define PACKETIZER_SRC_ID_EN to carry the source id.
module axis_packetizer
  import noc_pkt_pkg::*;
#(
  parameter int DATA_WIDTH          = AXIS_TDATA_W,
  parameter int MAX_ROUTERS_X       = 4,
  parameter int MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X),
  parameter int MAX_ROUTERS_Y       = 4,
  parameter int MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y),
  parameter int MAX_PACKAGES        = 4,
  parameter int ROUTER_X            = 0,
  parameter int ROUTER_Y            = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  axis_mosi_t                     in_mosi_i,
  output axis_miso_t                     in_miso_o,
  input  logic [MAX_ROUTERS_X_WIDTH-1:0] dest_x_i,
  input  logic [MAX_ROUTERS_Y_WIDTH-1:0] dest_y_i,
  output axis_mosi_t                     out_mosi_o,
  input  axis_miso_t                     out_miso_i
);

`ifdef PACKETIZER_SRC_ID_EN
  localparam bit SRC_ID_EN = 1'b1;
`else
  localparam bit SRC_ID_EN = 1'b0;
`endif

  localparam logic [NOC_X_W-1:0] SRC_X = SRC_ID_EN ? NOC_X_W'(ROUTER_X) : '0;
  localparam logic [NOC_Y_W-1:0] SRC_Y = SRC_ID_EN ? NOC_Y_W'(ROUTER_Y) : '0;

  localparam int               CNT_W    = (MAX_PACKAGES > 1) ? $clog2(MAX_PACKAGES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PACKAGES - 1);

  packetizer_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]          out_data_q, out_data_d;
  logic                           out_valid_q, out_valid_d;
  logic                           out_last_q, out_last_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [MAX_ROUTERS_X_WIDTH-1:0] dx_q, dx_d;
  logic [MAX_ROUTERS_Y_WIDTH-1:0] dy_q, dy_d;

  logic                  slot_free;
  logic                  in_ready;
  logic                  accept;
  logic                  cnt_at_last;
  logic [DATA_WIDTH-1:0] hdr_live;
  logic [DATA_WIDTH-1:0] hdr_latched;

  assign slot_free   = !out_valid_q || out_miso_i.tready;
  assign accept      = in_ready && in_mosi_i.tvalid;
  assign cnt_at_last = (cnt_q == CNT_LAST);

  // The first header of a burst uses the live destination; split headers reuse the latched one.
  assign hdr_live    = DATA_WIDTH'(pack_header(NOC_X_W'(dest_x_i), NOC_Y_W'(dest_y_i), SRC_X, SRC_Y));
  assign hdr_latched = DATA_WIDTH'(pack_header(NOC_X_W'(dx_q), NOC_Y_W'(dy_q), SRC_X, SRC_Y));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_mosi_i.tvalid && slot_free) state_d = BODY;
      BODY: begin
        if (accept) begin
          if (in_mosi_i.tlast)  state_d = IDLE;
          else if (cnt_at_last) state_d = CONT;
        end
      end
      CONT: if (slot_free) state_d = BODY;
      default: state_d = IDLE;
    endcase
  end

  // A free slot always retires the current flit; each state decides what, if anything, refills it.
  always_comb begin
    in_ready    = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    cnt_d       = cnt_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    if (slot_free) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_mosi_i.tvalid && slot_free) begin
          dx_d        = dest_x_i;
          dy_d        = dest_y_i;
          out_data_d  = hdr_live;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
        end
      end
      BODY: begin
        in_ready = slot_free;
        if (accept) begin
          out_data_d  = DATA_WIDTH'(in_mosi_i.tdata);
          out_valid_d = 1'b1;
          out_last_d  = in_mosi_i.tlast || cnt_at_last;
          cnt_d       = (in_mosi_i.tlast || cnt_at_last) ? '0 : cnt_q + 1'b1;
        end
      end
      CONT: begin
        if (slot_free) begin
          out_data_d  = hdr_latched;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      cnt_q       <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      cnt_q       <= cnt_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
    end
  end

  assign in_miso_o.tready  = in_ready;
  assign out_mosi_o.tdata  = AXIS_TDATA_W'(out_data_q);
  assign out_mosi_o.tvalid = out_valid_q;
  assign out_mosi_o.tlast  = out_last_q;

endmodule

// File: tb/tb_axis_packetizer.sv
// Randomized self-checking bench for axis_packetizer: a packet-level scoreboard built
// from burst length, MAX_PACKAGES and destination checks every flit leaving the block.
module tb_axis_packetizer;
  import noc_pkt_pkg::*;

  localparam int MAXP = 4;
  localparam int RX   = 1;
  localparam int RY   = 2;

`ifdef PACKETIZER_SRC_ID_EN
  localparam logic [31:0] SRC_BITS = 32'((RX << 4) | (RY << 6));
`else
  localparam logic [31:0] SRC_BITS = 32'h0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        last;
  } flit_t;

  logic       clk = 1'b0;
  logic       rst_n;
  axis_mosi_t in_mosi;
  axis_miso_t in_miso;
  axis_mosi_t out_mosi;
  axis_miso_t out_miso;
  logic [1:0] dest_x;
  logic [1:0] dest_y;

  int    ready_duty = 100;
  logic  mon_en     = 1'b0;
  flit_t exp_q[$];
  int    n_checks   = 0;
  int    n_pass     = 0;

  axis_packetizer #(
    .MAX_PACKAGES(MAXP),
    .ROUTER_X    (RX),
    .ROUTER_Y    (RY)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .in_mosi_i (in_mosi),
    .in_miso_o (in_miso),
    .dest_x_i  (dest_x),
    .dest_y_i  (dest_y),
    .out_mosi_o(out_mosi),
    .out_miso_i(out_miso)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected)
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] hdrValue(input int dx, input int dy);
    return 32'(dx + dy * 4) | SRC_BITS;
  endfunction

  // Every MAXP payload beats start a new packet; the final beat or the MAXP-th closes one.
  task automatic expectBurst(input int dx, input int dy, input logic [31:0] data[$]);
    int n;
    n = data.size();
    for (int i = 0; i < n; i++) begin
      if (i % MAXP == 0) exp_q.push_back('{hdrValue(dx, dy), 1'b0});
      exp_q.push_back('{data[i], (i == n - 1) || (i % MAXP == MAXP - 1)});
    end
  endtask

  task automatic applyStimulus(input int n, input int dx, input int dy,
                               input bit change_dest, input bit seq, input int gap_pct);
    logic [31:0] data[$];
    int t;
    for (int i = 0; i < n; i++) data.push_back(seq ? 32'(i) : $urandom);
    expectBurst(dx, dy, data);
    dest_x = 2'(dx);
    dest_y = 2'(dy);
    for (int i = 0; i < n; i++) begin
      in_mosi.tdata  = data[i];
      in_mosi.tlast  = (i == n - 1);
      in_mosi.tvalid = 1'b1;
      t = 0;
      while (1) begin
        @(negedge clk);
        if (in_miso.tready) break;
        t++;
        if (t > 500) begin
          checkOutput("in_handshake_timeout", 1, 0);
          break;
        end
      end
      @(posedge clk);
      #1;
      in_mosi.tvalid = 1'b0;
      if (change_dest) begin
        dest_x = 2'($urandom);
        dest_y = 2'($urandom);
      end
      if (i != n - 1 && $urandom_range(99) < 32'(gap_pct))
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
    end
  endtask

  task automatic waitDrain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    checkOutput("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    checkOutput("idle_after_burst", out_mosi.tvalid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_miso.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_miso.tready = ($urandom_range(99) < 32'(ready_duty));
    end
  end

  // Scoreboard plus stall-stability and ready-gating checks, sampled mid-cycle.
  initial begin
    logic        stalled;
    logic [32:0] held;
    flit_t       f;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checkOutput("in_ready_while_stalled",
                    {63'b0, in_miso.tready & out_mosi.tvalid & ~out_miso.tready}, 0);
        if (stalled) begin
          checkOutput("stall_valid", out_mosi.tvalid, 1);
          checkOutput("stall_flit", {out_mosi.tlast, out_mosi.tdata}, held);
        end
        if (out_mosi.tvalid && out_miso.tready) begin
          if (exp_q.size() == 0) begin
            checkOutput("extra_flit", {out_mosi.tlast, out_mosi.tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            f = exp_q.pop_front();
            checkOutput("flit", {out_mosi.tlast, out_mosi.tdata}, {f.last, f.data});
          end
        end
        stalled = out_mosi.tvalid && !out_miso.tready;
        held    = {out_mosi.tlast, out_mosi.tdata};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    bit found;
    rst_n   = 1'b0;
    in_mosi = '0;
    dest_x  = '0;
    dest_y  = '0;
    #2;
    checkOutput("rst_tvalid", out_mosi.tvalid, 0);
    checkOutput("rst_tlast", out_mosi.tlast, 0);
    checkOutput("rst_tdata", out_mosi.tdata, 0);
    checkOutput("rst_in_ready", in_miso.tready, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    ready_duty = 100;
    applyStimulus(1, 2, 3, 1'b0, 1'b1, 0);
    waitDrain();
    applyStimulus(10, 1, 2, 1'b1, 1'b1, 0);
    waitDrain();
    applyStimulus(4, 3, 1, 1'b0, 1'b1, 0);
    waitDrain();
    applyStimulus(8, 0, 0, 1'b1, 1'b0, 0);
    waitDrain();

    ready_duty = 30;
    for (int b = 0; b < 50; b++)
      applyStimulus($urandom_range(1, 12), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'b1, 1'b0, 30);
    waitDrain();

    // Reset while the second body beat sits in the output register.
    ready_duty = 100;
    repeat (2) @(posedge clk);
    #1;
    mon_en         = 1'b0;
    dest_x         = 2'd1;
    dest_y         = 2'd1;
    in_mosi.tdata  = 32'd100;
    in_mosi.tlast  = 1'b0;
    in_mosi.tvalid = 1'b1;
    found          = 1'b0;
    for (int t = 0; t < 60 && !found; t++) begin
      @(negedge clk);
      if (out_mosi.tvalid && out_mosi.tdata == 32'd101) begin
        found = 1'b1;
      end else if (in_miso.tready) begin
        @(posedge clk);
        #1;
        in_mosi.tdata = in_mosi.tdata + 32'd1;
      end
    end
    checkOutput("reach_second_beat", found, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_tvalid", out_mosi.tvalid, 0);
    checkOutput("midrst_in_ready", in_miso.tready, 0);
    in_mosi.tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    applyStimulus(5, 3, 0, 1'b1, 1'b1, 0);
    waitDrain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_packetizer.md
Name: axis_packetizer

Overview:
- Network-interface stage directly upstream of a router local input channel.
- Takes a raw payload AXI-Stream from a local node and prepends a routing header flit carrying destination X/Y; the router arbiter decodes this flit into its target coordinates.
- Splits long payload bursts into packets of at most MAX_PACKAGES body flits and re-issues the header for each packet.
- Output is registered; one instance per local request or response channel.

Parameters:
- DATA_WIDTH, 32, TDATA width; must be at least 2*(MAX_ROUTERS_X_WIDTH+MAX_ROUTERS_Y_WIDTH).
- MAX_ROUTERS_X, 4, mesh columns.
- MAX_ROUTERS_X_WIDTH, $clog2(MAX_ROUTERS_X), X field width.
- MAX_ROUTERS_Y, 4, mesh rows.
- MAX_ROUTERS_Y_WIDTH, $clog2(MAX_ROUTERS_Y), Y field width.
- MAX_PACKAGES, 4, maximum body flits per packet (>=1).
- ROUTER_X, 0, X coordinate of the attached router.
- ROUTER_Y, 0, Y coordinate of the attached router.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- in_mosi_i  in  axis_mosi_t  payload from node (TDATA, TVALID, TLAST).
- in_miso_o  out  axis_miso_t  TREADY to node.
- dest_x_i  in  MAX_ROUTERS_X_WIDTH  destination X; sampled on the first beat of a node burst.
- dest_y_i  in  MAX_ROUTERS_Y_WIDTH  destination Y; sampled on the first beat of a node burst.
- out_mosi_o  out  axis_mosi_t  packet stream to router local input.
- out_miso_i  in  axis_miso_t  TREADY from router.

Behaviour:
- Reset (async, rst_n_i low):
  - state=IDLE; out TVALID=0, TLAST=0, TDATA=0; in TREADY=0.
  - Body counter=0; latched destination=0.
- Output register: loaded when "slot free", i.e. out TVALID=0 or out TREADY=1. It holds while TVALID=1 and TREADY=0.
- IDLE:
  - On in TVALID=1 with the slot free: latch dest_x_i/dest_y_i; load a header into the output (TLAST=0); go to BODY.
  - in TREADY=0 throughout, so the first payload beat is not consumed.
  - Header appears on out one cycle after in TVALID is first seen.
- Header layout:
  - TDATA[MAX_ROUTERS_X_WIDTH-1:0] = dest X.
  - Next MAX_ROUTERS_Y_WIDTH bits = dest Y.
  - Remaining bits = 0, unless the optional feature is compiled in.
- BODY:
  - in TREADY = slot free.
  - Each accepted beat is copied to out and the counter increments.
  - out TLAST=1 when in TLAST=1 or counter==MAX_PACKAGES-1.
- Transitions from BODY after an accepted beat:
  - in TLAST=1 → IDLE; counter=0.
  - Else, counter reached MAX_PACKAGES-1 → CONT; counter=0.
  - Else stay in BODY.
- CONT:
  - in TREADY=0.
  - When the slot is free, emit a header built from the latched destination (not the live dest_x_i/dest_y_i) and return to BODY.
  - The node sees no data loss, only a one-beat stall per split.
- Simultaneous in TLAST=1 and counter==MAX_PACKAGES-1: single TLAST; go to IDLE, not CONT.
- in TVALID dropping mid-burst: state holds; no output bubble is filled.
- Throughput: one flit per cycle in BODY under continuous TREADY. Overhead is one header cycle per packet.
- Destination equal to (ROUTER_X, ROUTER_Y): legal; the router delivers the packet back to the local port.
- Reset mid-packet: the partial packet is discarded; the router sees TVALID drop immediately (asynchronous).
- Output is never combinationally dependent on in_mosi_i.

Optional Feature:
- Macro: PACKETIZER_SRC_ID_EN.
- Defined: header bits directly above dest Y carry ROUTER_X, then ROUTER_Y, letting the far-end depacketizer route responses back.
- Undefined: those bits are 0; no other change in timing or state behaviour.

Decomposition:
- Shared package noc_pkt_pkg:
  - header field offsets and widths (HDR_DX_LSB, HDR_DY_LSB, HDR_SX_LSB, HDR_SY_LSB);
  - packetizer_state_t enum {IDLE, BODY, CONT};
  - function pack_header(dx, dy, sx, sy).
- The router arbiter reuses the same offsets.
- No sub-module; the output register is inline.

Test Plan:
- Single-beat burst, dest (2,3), MAX_PACKAGES=4, out TREADY=1:
  - out = header, TDATA[1:0]=2, TDATA[3:2]=3, TLAST=0;
  - then the payload beat with TLAST=1;
  - return to IDLE.
- 10-beat burst, data 0..9, MAX_PACKAGES=4:
  - out = H,0,1,2,3(L),H,4,5,6,7(L),H,8,9(L);
  - all three headers carry the first-sampled destination even though dest_x_i changes mid-burst.
- 4-beat burst with TLAST on beat 3 (boundary coincidence):
  - exactly one packet H,d0..d3(L); no empty trailing header.
- Random out TREADY at 30% duty, 50 bursts:
  - no flit dropped or duplicated;
  - TDATA/TLAST stable while stalled;
  - in TREADY never high in IDLE or CONT.
- Reset asserted during the second body beat:
  - out TVALID=0 in the same cycle;
  - after release, the next burst starts with a fresh header.
- PACKETIZER_SRC_ID_EN with ROUTER_X=1, ROUTER_Y=2:
  - header TDATA[5:4]=1 and TDATA[7:6]=2;
  - without the macro, TDATA[31:4]=0.
